elevator_call_scheduler: RTL and testbench

Collects floor call requests, keeps them in a pending bitmap, and picks the next stop for the elevator controller using a SCAN (sweep) policy. It sits directly upstream of the elevator controller. It drives that controller's target floor and consumes its floor position and door status to retire served calls. One request is accepted per cycle. Closer stops found along the current direction of travel re-target the car while it is moving.

---
 rtl/elevator_call_scheduler.sv | 237 +++++++++++++++++++++++
 tb/tb_elevator_call_scheduler.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/elevator_call_scheduler.sv
// elevator_call_scheduler
//
// Collects floor call requests into a pending bitmap and hands the next
// stop to the downstream elevator controller using a SCAN (sweep) policy.
// Served calls are retired from the controller's floor position and door
// status. While the car is travelling, a closer pending stop found along
// the current direction of travel re-targets the car.
//
// State table:
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | no trip outstanding; waits for pending calls with on=1
//   ST_SELECT  | one cycle: pick the next stop, raise target_valid
//   ST_TRAVEL  | trip outstanding; may re-target to a closer stop en route
//   ST_SERVICE | call retired; waits for the door to close
//
// Ports:
//   clk           system clock, rising edge
//   reset_n       synchronous active-low reset
//   on            scheduler enable (gates request capture and new trips)
//   req_valid     call request strobe
//   req_floor     requested floor, valid with req_valid
//   cur_floor     current car floor from the controller
//   door_open     car door open from the controller
//   target_floor  registered stop handed to the controller
//   target_valid  high while a trip to target_floor is outstanding
//   dir_up        sweep direction, 1 = up
//   pending       bitmap of outstanding calls
//   queue_count   popcount of pending
//   busy          high whenever the state is not ST_IDLE

module elevator_call_scheduler #(
    parameter int NUM_FLOORS = 16,
    parameter int FLOOR_W    = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  on,
    input  logic                  req_valid,
    input  logic [FLOOR_W-1:0]    req_floor,
    input  logic [FLOOR_W-1:0]    cur_floor,
    input  logic                  door_open,
    output logic [FLOOR_W-1:0]    target_floor,
    output logic                  target_valid,
    output logic                  dir_up,
    output logic [NUM_FLOORS-1:0] pending,
    output logic [FLOOR_W:0]      queue_count,
    output logic                  busy
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SELECT  = 2'd1;
    localparam logic [1:0] ST_TRAVEL  = 2'd2;
    localparam logic [1:0] ST_SERVICE = 2'd3;

    logic [1:0]            state_q,        state_d;
    logic [NUM_FLOORS-1:0] pending_q,      pending_d;
    logic [FLOOR_W-1:0]    target_q,       target_d;
    logic                  target_valid_q, target_valid_d;
    logic                  dir_up_q,       dir_up_d;
    logic [FLOOR_W:0]      queue_count_q,  queue_count_d;
    logic                  busy_q,         busy_d;

    // Search results over the registered pending bitmap, relative to cur_floor.
    logic                  cur_hit;
    logic                  above_found;
    logic [FLOOR_W-1:0]    above_idx;
    logic                  below_found;
    logic [FLOOR_W-1:0]    below_idx;

    logic                  req_ok;
    logic                  arrived;
    logic                  retarget;
    logic [FLOOR_W-1:0]    retarget_idx;

    // Nearest pending floor on each side of the car. Above is scanned top-down
    // and below bottom-up so the last hit is the one closest to cur_floor.
    always_comb begin
        cur_hit     = 1'b0;
        above_found = 1'b0;
        above_idx   = '0;
        below_found = 1'b0;
        below_idx   = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending_q[i] && (i == int'(cur_floor))) begin
                cur_hit = 1'b1;
            end
        end
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending_q[i] && (i > int'(cur_floor))) begin
                above_found = 1'b1;
                above_idx   = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending_q[i] && (i < int'(cur_floor))) begin
                below_found = 1'b1;
                below_idx   = FLOOR_W'(i);
            end
        end
    end

    // A call for the floor whose door is already open is being served now.
    assign req_ok = on && req_valid
                    && (int'(req_floor) < NUM_FLOORS)
                    && !((req_floor == cur_floor) && door_open);

    assign arrived = (cur_floor == target_q) && door_open;

    // The target itself is pending, so the nearest hit in the travel direction
    // is either the target or a stop strictly between the car and the target.
    always_comb begin
        retarget     = 1'b0;
        retarget_idx = target_q;
        if (dir_up_q) begin
            if ((cur_floor < target_q) && above_found && (above_idx < target_q)) begin
                retarget     = 1'b1;
                retarget_idx = above_idx;
            end
        end else begin
            if ((cur_floor > target_q) && below_found && (below_idx > target_q)) begin
                retarget     = 1'b1;
                retarget_idx = below_idx;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        pending_d      = pending_q;
        target_d       = target_q;
        target_valid_d = target_valid_q;
        dir_up_d       = dir_up_q;

        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (req_ok && (i == int'(req_floor))) begin
                pending_d[i] = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if ((pending_q != '0) && on) begin
                    state_d = ST_SELECT;
                end
            end

            ST_SELECT: begin
                state_d        = ST_TRAVEL;
                target_valid_d = 1'b1;
                if (cur_hit) begin
                    target_d = cur_floor;
                end else if (dir_up_q && above_found) begin
                    target_d = above_idx;
                end else if (!dir_up_q && below_found) begin
                    target_d = below_idx;
                end else if (dir_up_q && below_found) begin
                    dir_up_d = 1'b0;
                    target_d = below_idx;
                end else if (!dir_up_q && above_found) begin
                    dir_up_d = 1'b1;
                    target_d = above_idx;
                end else begin
                    // Nothing to serve; do not start a trip.
                    state_d        = ST_IDLE;
                    target_valid_d = 1'b0;
                end
            end

            ST_TRAVEL: begin
                if (arrived) begin
                    // Applied after request capture so the retirement clear wins.
                    for (int i = 0; i < NUM_FLOORS; i++) begin
                        if (i == int'(target_q)) begin
                            pending_d[i] = 1'b0;
                        end
                    end
                    target_valid_d = 1'b0;
                    state_d        = ST_SERVICE;
                end else if (retarget) begin
                    target_d = retarget_idx;
                end
            end

            ST_SERVICE: begin
                if (!door_open) begin
                    if ((pending_q != '0) && on) begin
                        state_d = ST_SELECT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        queue_count_d = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            queue_count_d = queue_count_d + (FLOOR_W + 1)'(pending_d[i]);
        end
    end

    assign busy_d = (state_d != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            pending_q      <= '0;
            target_q       <= '0;
            target_valid_q <= 1'b0;
            dir_up_q       <= 1'b1;
            queue_count_q  <= '0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            target_q       <= target_d;
            target_valid_q <= target_valid_d;
            dir_up_q       <= dir_up_d;
            queue_count_q  <= queue_count_d;
            busy_q         <= busy_d;
        end
    end

    assign target_floor = target_q;
    assign target_valid = target_valid_q;
    assign dir_up       = dir_up_q;
    assign pending      = pending_q;
    assign queue_count  = queue_count_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed bench for elevator_call_scheduler: a table of one-edge vectors
// with hand-computed expected outputs, plus short sequences for retarget
// and reset in the middle of a trip.

module tb_elevator_call_scheduler;

    logic        clk;
    logic        reset_n;
    logic        on;
    logic        req_valid;
    logic [3:0]  req_floor;
    logic [3:0]  cur_floor;
    logic        door_open;
    logic [3:0]  target_floor;
    logic        target_valid;
    logic        dir_up;
    logic [15:0] pending;
    logic [4:0]  queue_count;
    logic        busy;

    int checks = 0;
    int errors = 0;

    elevator_call_scheduler #(.NUM_FLOORS(16), .FLOOR_W(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .on           (on),
        .req_valid    (req_valid),
        .req_floor    (req_floor),
        .cur_floor    (cur_floor),
        .door_open    (door_open),
        .target_floor (target_floor),
        .target_valid (target_valid),
        .dir_up       (dir_up),
        .pending      (pending),
        .queue_count  (queue_count),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rn;
        logic        en;
        logic        rv;
        logic [3:0]  rf;
        logic [3:0]  cf;
        logic        door;
        logic [15:0] pend;
        logic [3:0]  tf;
        logic        tv;
        logic        up;
        logic [4:0]  qc;
        logic        bsy;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drive(input logic rn, input logic en, input logic rv,
                         input logic [3:0] rf, input logic [3:0] cf, input logic door);
        reset_n   = rn;
        on        = en;
        req_valid = rv;
        req_floor = rf;
        cur_floor = cf;
        door_open = door;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [15:0] pend, input logic [3:0] tf,
                             input logic tv, input logic up, input logic [4:0] qc, input logic bsy);
        check({tag, "_pending"},      32'(pending),      32'(pend));
        check({tag, "_target_floor"}, 32'(target_floor), 32'(tf));
        check({tag, "_target_valid"}, 32'(target_valid), 32'(tv));
        check({tag, "_dir_up"},       32'(dir_up),       32'(up));
        check({tag, "_queue_count"},  32'(queue_count),  32'(qc));
        check({tag, "_busy"},         32'(busy),         32'(bsy));
    endtask

    initial begin
        //            rn  on  rv  rf    cf    door  pend      tf    tv  up  qc    busy
        // reset, then request 4 from floor 0: 2-cycle latency
        vecs[0]  = '{1'b0,1'b0,1'b0,4'd0,4'd0,1'b0,16'h0000,4'd0,1'b0,1'b1,5'd0,1'b0};
        vecs[1]  = '{1'b0,1'b1,1'b0,4'd0,4'd0,1'b0,16'h0000,4'd0,1'b0,1'b1,5'd0,1'b0};
        vecs[2]  = '{1'b1,1'b1,1'b1,4'd4,4'd0,1'b0,16'h0010,4'd0,1'b0,1'b1,5'd1,1'b0};
        vecs[3]  = '{1'b1,1'b1,1'b0,4'd0,4'd0,1'b0,16'h0010,4'd0,1'b0,1'b1,5'd1,1'b1};
        vecs[4]  = '{1'b1,1'b1,1'b0,4'd0,4'd0,1'b0,16'h0010,4'd4,1'b1,1'b1,5'd1,1'b1};
        // arrive at 4 with door open: retire; door closes: IDLE
        vecs[5]  = '{1'b1,1'b1,1'b0,4'd0,4'd4,1'b1,16'h0000,4'd4,1'b0,1'b1,5'd0,1'b1};
        vecs[6]  = '{1'b1,1'b1,1'b0,4'd0,4'd4,1'b0,16'h0000,4'd4,1'b0,1'b1,5'd0,1'b0};
        // drop rules: door open at requested floor, on=0
        vecs[7]  = '{1'b1,1'b1,1'b1,4'd3,4'd3,1'b1,16'h0000,4'd4,1'b0,1'b1,5'd0,1'b0};
        vecs[8]  = '{1'b1,1'b0,1'b1,4'd6,4'd3,1'b0,16'h0000,4'd4,1'b0,1'b1,5'd0,1'b0};
        // request 7, then a duplicate for 7
        vecs[9]  = '{1'b1,1'b1,1'b1,4'd7,4'd3,1'b0,16'h0080,4'd4,1'b0,1'b1,5'd1,1'b0};
        vecs[10] = '{1'b1,1'b1,1'b1,4'd7,4'd3,1'b0,16'h0080,4'd4,1'b0,1'b1,5'd1,1'b1};
        vecs[11] = '{1'b1,1'b1,1'b0,4'd0,4'd3,1'b0,16'h0080,4'd7,1'b1,1'b1,5'd1,1'b1};
        // SCAN reversal: pending {2,7}, car at 5 going up
        vecs[12] = '{1'b0,1'b1,1'b0,4'd0,4'd3,1'b0,16'h0000,4'd0,1'b0,1'b1,5'd0,1'b0};
        vecs[13] = '{1'b1,1'b1,1'b1,4'd2,4'd5,1'b0,16'h0004,4'd0,1'b0,1'b1,5'd1,1'b0};
        vecs[14] = '{1'b1,1'b1,1'b1,4'd7,4'd5,1'b0,16'h0084,4'd0,1'b0,1'b1,5'd2,1'b1};
        vecs[15] = '{1'b1,1'b1,1'b0,4'd0,4'd5,1'b0,16'h0084,4'd7,1'b1,1'b1,5'd2,1'b1};
        vecs[16] = '{1'b1,1'b1,1'b0,4'd0,4'd7,1'b1,16'h0004,4'd7,1'b0,1'b1,5'd1,1'b1};
        vecs[17] = '{1'b1,1'b1,1'b0,4'd0,4'd7,1'b0,16'h0004,4'd7,1'b0,1'b1,5'd1,1'b1};
        vecs[18] = '{1'b1,1'b1,1'b0,4'd0,4'd7,1'b0,16'h0004,4'd2,1'b1,1'b0,5'd1,1'b1};
        // on=0 mid-trip: request dropped, trip completes, then IDLE
        vecs[19] = '{1'b1,1'b0,1'b1,4'd6,4'd2,1'b1,16'h0000,4'd2,1'b0,1'b0,5'd0,1'b1};
        vecs[20] = '{1'b1,1'b0,1'b0,4'd0,4'd2,1'b0,16'h0000,4'd2,1'b0,1'b0,5'd0,1'b0};
        // pending kept while on=0; dispatch resumes with reversal to up
        vecs[21] = '{1'b1,1'b1,1'b1,4'd6,4'd2,1'b0,16'h0040,4'd2,1'b0,1'b0,5'd1,1'b0};
        vecs[22] = '{1'b1,1'b0,1'b0,4'd0,4'd2,1'b0,16'h0040,4'd2,1'b0,1'b0,5'd1,1'b0};
        vecs[23] = '{1'b1,1'b1,1'b0,4'd0,4'd2,1'b0,16'h0040,4'd2,1'b0,1'b0,5'd1,1'b1};
        vecs[24] = '{1'b1,1'b1,1'b0,4'd0,4'd2,1'b0,16'h0040,4'd6,1'b1,1'b1,5'd1,1'b1};

        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        #1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rn, vecs[i].en, vecs[i].rv, vecs[i].rf, vecs[i].cf, vecs[i].door);
            step();
            check_all($sformatf("v%0d", i), vecs[i].pend, vecs[i].tf, vecs[i].tv,
                      vecs[i].up, vecs[i].qc, vecs[i].bsy);
        end

        // Retarget toward a closer stop ahead: car at 1 heading to 9, call at 5.
        begin
            int n;
            drive(1'b0, 1'b1, 1'b0, 4'd0, 4'd1, 1'b0);
            step();
            drive(1'b1, 1'b1, 1'b1, 4'd9, 4'd1, 1'b0);
            step();
            drive(1'b1, 1'b1, 1'b0, 4'd0, 4'd1, 1'b0);
            n = 0;
            while (!target_valid && n < 8) begin
                step();
                n++;
            end
            check("rt_tv_rise", 32'(target_valid), 32'd1);
            check("rt_latency", 32'(n), 32'd2);
            check("rt_first_target", 32'(target_floor), 32'd9);
            drive(1'b1, 1'b1, 1'b1, 4'd5, 4'd1, 1'b0);
            step();
            check("rt_pending", 32'(pending), 32'h0220);
            check("rt_not_yet", 32'(target_floor), 32'd9);
            drive(1'b1, 1'b1, 1'b0, 4'd0, 4'd1, 1'b0);
            step();
            check("rt_new_target", 32'(target_floor), 32'd5);
            check("rt_valid_held", 32'(target_valid), 32'd1);
            check("rt_busy", 32'(busy), 32'd1);
        end

        // A call behind the car does not retarget.
        begin
            int n;
            drive(1'b0, 1'b1, 1'b0, 4'd0, 4'd1, 1'b0);
            step();
            drive(1'b1, 1'b1, 1'b1, 4'd9, 4'd1, 1'b0);
            step();
            drive(1'b1, 1'b1, 1'b0, 4'd0, 4'd1, 1'b0);
            n = 0;
            while (!target_valid && n < 8) begin
                step();
                n++;
            end
            check("nb_tv_rise", 32'(target_valid), 32'd1);
            drive(1'b1, 1'b1, 1'b1, 4'd0, 4'd1, 1'b0);
            step();
            check("nb_pending", 32'(pending), 32'h0201);
            drive(1'b1, 1'b1, 1'b0, 4'd0, 4'd1, 1'b0);
            step();
            step();
            check("nb_target_kept", 32'(target_floor), 32'd9);
            check("nb_valid_kept", 32'(target_valid), 32'd1);
        end

        // Reset while travelling with pending = 0x0222.
        drive(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        step();
        drive(1'b1, 1'b1, 1'b1, 4'd1, 4'd0, 1'b0);
        step();
        drive(1'b1, 1'b1, 1'b1, 4'd5, 4'd0, 1'b0);
        step();
        drive(1'b1, 1'b1, 1'b1, 4'd9, 4'd0, 1'b0);
        step();
        check_all("mt_travel", 16'h0222, 4'd1, 1'b1, 1'b1, 5'd3, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        step();
        check_all("mt_reset", 16'h0000, 4'd0, 1'b0, 1'b1, 5'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
